// File: rtl/bulk_mem_arbiter.sv
// Round-robin arbiter sharing one line-granular backing-memory port between N_PORTS caches.
// Dumping caches get priority; read ownership is held until the line response returns.
module bulk_mem_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned PTR_W   = $clog2(N_PORTS),
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned STRB_W  = LINE_W / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    // cache side, one slot per port
    input  logic [N_PORTS-1:0]             cs_req_valid,
    input  logic [N_PORTS-1:0][ADDR_W-1:0] cs_req_addr,
    input  logic [N_PORTS-1:0]             cs_req_write,
    input  logic [N_PORTS-1:0][STRB_W-1:0] cs_req_wstrb,
    input  logic [N_PORTS-1:0][LINE_W-1:0] cs_req_wdata,
    input  logic [N_PORTS-1:0]             cs_dumping_cache,
    output logic [N_PORTS-1:0]             cs_req_ready,
    output logic [N_PORTS-1:0]             cs_resp_valid,
    output logic [N_PORTS-1:0][LINE_W-1:0] cs_resp_rdata,
    // memory side
    output logic                           mem_req_valid,
    output logic [ADDR_W-1:0]              mem_req_addr,
    output logic                           mem_req_write,
    output logic [STRB_W-1:0]              mem_req_wstrb,
    output logic [LINE_W-1:0]              mem_req_wdata,
    output logic                           mem_dumping_cache,
    input  logic                           mem_req_ready,
    input  logic                           mem_resp_valid,
    input  logic [LINE_W-1:0]              mem_resp_rdata,
    // status
    output logic [PTR_W-1:0]               owner,
    output logic                           err_spurious_resp
);

    localparam logic [1:0] StArb      = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StWaitResp = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               err_q, err_d;

    logic [N_PORTS-1:0] cand;
    logic [PTR_W-1:0]   scan_idx;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               fwd_en;
    logic [PTR_W-1:0]   sel_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (32'(p) + 32'd1 >= N_PORTS) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Dumping ports, when any are requesting, shadow all other candidates.
    always_comb begin
        cand      = (|(cs_req_valid & cs_dumping_cache)) ? (cs_req_valid & cs_dumping_cache)
                                                         : cs_req_valid;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            scan_idx = PTR_W'((32'(rr_q) + i) % N_PORTS);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign fwd_en  = rst && (((state_q == StArb) && win_found) || (state_q == StIssue));
    assign sel_idx = (state_q == StArb) ? win_idx : owner_q;

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_write = 1'b0;
        mem_req_wstrb = '0;
        mem_req_wdata = '0;
        cs_req_ready  = '0;
        cs_resp_valid = '0;
        cs_resp_rdata = '0;
        if (fwd_en) begin
            mem_req_valid         = cs_req_valid[sel_idx];
            mem_req_addr          = cs_req_addr[sel_idx];
            mem_req_write         = cs_req_write[sel_idx];
            mem_req_wstrb         = cs_req_wstrb[sel_idx];
            mem_req_wdata         = cs_req_wdata[sel_idx];
            cs_req_ready[sel_idx] = mem_req_ready;
        end
        if (rst && (state_q == StWaitResp)) begin
            cs_resp_valid[owner_q] = mem_resp_valid;
            cs_resp_rdata[owner_q] = mem_resp_rdata;
        end
    end

    assign mem_dumping_cache = |cs_dumping_cache;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        // Responses outside WAIT_RESP are dropped and latched as an error.
        err_d   = err_q | (mem_resp_valid && (state_q != StWaitResp));
        case (state_q)
            StArb: begin
                if (win_found) begin
                    owner_d = win_idx;
                    if (mem_req_ready) begin
                        if (cs_req_write[win_idx]) begin
                            rr_d = ptr_inc(win_idx);
                        end else begin
                            state_d = StWaitResp;
                        end
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!cs_req_valid[owner_q]) begin
                    state_d = StArb;
                end else if (mem_req_ready) begin
                    if (cs_req_write[owner_q]) begin
                        state_d = StArb;
                        rr_d    = ptr_inc(owner_q);
                    end else begin
                        state_d = StWaitResp;
                    end
                end
            end
            StWaitResp: begin
                if (mem_resp_valid) begin
                    state_d = StArb;
                    rr_d    = ptr_inc(owner_q);
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StArb;
            rr_q    <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign owner             = owner_q;
    assign err_spurious_resp = err_q;

endmodule

// File: tb/tb_bulk_mem_arbiter.sv
// Directed bench for bulk_mem_arbiter: transaction-level model checked every cycle
// plus literal expectations for grant order, latency and error flagging.
module tb_bulk_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int LW = 64;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]         req_valid, req_write, dumping;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][SW-1:0] req_wstrb;
    logic [NP-1:0][LW-1:0] req_wdata;
    logic [NP-1:0]         req_ready, resp_valid;
    logic [NP-1:0][LW-1:0] resp_rdata;
    logic                  mem_req_valid, mem_req_write, mem_dumping_cache;
    logic [AW-1:0]         mem_req_addr;
    logic [SW-1:0]         mem_req_wstrb;
    logic [LW-1:0]         mem_req_wdata;
    logic                  mem_ready, mem_resp_valid;
    logic [LW-1:0]         mem_resp_rdata;
    logic [0:0]            owner;
    logic                  err;

    logic          auto_en, auto_valid, man_valid;
    logic [LW-1:0] auto_rdata, man_rdata;
    int            resp_lat;

    assign mem_resp_valid = auto_en ? auto_valid : man_valid;
    assign mem_resp_rdata = auto_en ? auto_rdata : man_rdata;

    bulk_mem_arbiter #(
        .N_PORTS(NP),
        .ADDR_W (AW),
        .LINE_W (LW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cs_req_valid     (req_valid),
        .cs_req_addr      (req_addr),
        .cs_req_write     (req_write),
        .cs_req_wstrb     (req_wstrb),
        .cs_req_wdata     (req_wdata),
        .cs_dumping_cache (dumping),
        .cs_req_ready     (req_ready),
        .cs_resp_valid    (resp_valid),
        .cs_resp_rdata    (resp_rdata),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_write    (mem_req_write),
        .mem_req_wstrb    (mem_req_wstrb),
        .mem_req_wdata    (mem_req_wdata),
        .mem_dumping_cache(mem_dumping_cache),
        .mem_req_ready    (mem_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_rdata   (mem_resp_rdata),
        .owner            (owner),
        .err_spurious_resp(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: a read accepted in cycle N answers in cycle N+resp_lat.
    initial begin : responder
        int            cnt;
        logic [LW-1:0] data;
        cnt        = 0;
        data       = '0;
        auto_valid = 1'b0;
        auto_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && mem_req_valid && mem_ready && !mem_req_write) begin
                cnt  = resp_lat;
                data = {mem_req_addr, ~mem_req_addr};
            end
            @(posedge clk);
            #1;
            if (cnt > 0) begin
                cnt--;
                auto_valid = (cnt == 0);
                auto_rdata = (cnt == 0) ? data : '0;
            end else begin
                auto_valid = 1'b0;
                auto_rdata = '0;
            end
        end
    end

    // Grant / response log
    int            g_port[$];
    int            g_cyc[$];
    int            r_cyc[$];
    int            r_cnt[NP] = '{default: 0};
    logic [LW-1:0] r_last[NP];

    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    g_port.push_back(p);
                    g_cyc.push_back(cyc);
                end
                if (resp_valid[p]) begin
                    r_cnt[p]++;
                    r_last[p] = resp_rdata[p];
                    r_cyc.push_back(cyc);
                end
            end
        end
    end

    // Transaction-level model: who is locked, who awaits a line, round-robin origin.
    int m_rr, m_owner, m_lock, m_pend;
    bit m_err;

    function automatic int model_pick();
        bit any_dump  = 1'b0;
        int best      = -1;
        int best_dist = NP;
        for (int p = 0; p < NP; p++) if (req_valid[p] && dumping[p]) any_dump = 1'b1;
        for (int p = 0; p < NP; p++) begin
            if (req_valid[p] && (!any_dump || dumping[p]) && ((p - m_rr + NP) % NP) < best_dist) begin
                best_dist = (p - m_rr + NP) % NP;
                best      = p;
            end
        end
        return best;
    endfunction

    int                    e_sel;
    logic                  e_mv, e_wr;
    logic [AW-1:0]         e_addr;
    logic [SW-1:0]         e_strb;
    logic [LW-1:0]         e_wd;
    logic [NP-1:0]         e_ready, e_rv;
    logic [NP-1:0][LW-1:0] e_rd;

    always @(negedge clk) begin
        if (!rst) begin
            m_rr = 0; m_owner = 0; m_lock = -1; m_pend = -1; m_err = 1'b0;
            chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
            chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_rdata1", resp_rdata[1], 64'd0);
            chk("rst_owner", 64'(owner), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
        end else begin
            if (m_pend >= 0) e_sel = -1;
            else if (m_lock >= 0) e_sel = m_lock;
            else e_sel = model_pick();
            e_mv = 1'b0; e_wr = 1'b0; e_addr = '0; e_strb = '0; e_wd = '0;
            e_ready = '0; e_rv = '0; e_rd = '0;
            if (e_sel >= 0) begin
                e_mv           = req_valid[e_sel];
                e_wr           = req_write[e_sel];
                e_addr         = req_addr[e_sel];
                e_strb         = req_wstrb[e_sel];
                e_wd           = req_wdata[e_sel];
                e_ready[e_sel] = mem_ready;
            end
            if (m_pend >= 0) begin
                e_rv[m_pend] = mem_resp_valid;
                e_rd[m_pend] = mem_resp_rdata;
            end
            chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mv));
            chk("mem_req_addr", 64'(mem_req_addr), 64'(e_addr));
            chk("mem_req_write", 64'(mem_req_write), 64'(e_wr));
            chk("mem_req_wstrb", 64'(mem_req_wstrb), 64'(e_strb));
            chk("mem_req_wdata", mem_req_wdata, e_wd);
            chk("mem_dumping", 64'(mem_dumping_cache), 64'(|dumping));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("resp_rdata0", resp_rdata[0], e_rd[0]);
            chk("resp_rdata1", resp_rdata[1], e_rd[1]);
            chk("owner", 64'(owner), 64'(m_owner));
            chk("err_spurious", 64'(err), 64'(m_err));
            // advance to the state after the coming edge
            if (mem_resp_valid && m_pend < 0) m_err = 1'b1;
            if (m_pend >= 0) begin
                if (mem_resp_valid) begin
                    m_rr   = (m_pend + 1) % NP;
                    m_pend = -1;
                end
            end else if (e_sel >= 0) begin
                m_owner = e_sel;
                if (!req_valid[e_sel]) begin
                    m_lock = -1;
                end else if (mem_ready) begin
                    m_lock = -1;
                    if (req_write[e_sel]) m_rr = (e_sel + 1) % NP;
                    else m_pend = e_sel;
                end else begin
                    m_lock = e_sel;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grants(input int target, input int maxc, input string name);
        int n = 0;
        while (g_port.size() < target) begin
            if (n >= maxc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: timeout, got %0d grants expected %0d", name, g_port.size(), target);
                return;
            end
            step(1);
            n++;
        end
    endtask

    task automatic wait_resps(input int p, input int target, input int maxc, input string name);
        int n = 0;
        while (r_cnt[p] < target) begin
            if (n >= maxc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: timeout, got %0d responses expected %0d", name, r_cnt[p], target);
                return;
            end
            step(1);
            n++;
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [LW-1:0] d);
        req_valid[p] = v;
        req_write[p] = w;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_wstrb[p] = w ? 8'hff : 8'h00;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_write = '0;
        dumping   = '0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    int gb, rb0, rb1, rc;

    initial begin : stim
        rst = 1'b0;
        req_valid = '0; req_write = '0; dumping = '0;
        req_addr = '0; req_wstrb = '0; req_wdata = '0;
        mem_ready = 1'b0; auto_en = 1'b1; man_valid = 1'b0; man_rdata = '0; resp_lat = 3;
        step(2);
        @(negedge clk);
        chk("reset_owner", 64'(owner), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_mem_valid", 64'(mem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);

        // Lone read from port 0, 3-cycle response
        mem_ready = 1'b1; resp_lat = 3;
        gb = g_port.size(); rb0 = r_cnt[0]; rb1 = r_cnt[1];
        set_req(0, 1'b1, 1'b0, 32'h1000, '0);
        wait_grants(gb + 1, 20, "t1_grant");
        req_valid[0] = 1'b0;
        wait_resps(0, rb0 + 1, 20, "t1_resp");
        step(3);
        chk("t1_grant_port", 64'(g_port[gb]), 64'd0);
        chk("t1_resp_count_p0", 64'(r_cnt[0] - rb0), 64'd1);
        chk("t1_resp_count_p1", 64'(r_cnt[1] - rb1), 64'd0);
        chk("t1_rdata", r_last[0], 64'h0000_1000_ffff_efff);
        chk("t1_latency", 64'(r_cyc[r_cyc.size() - 1] - g_cyc[gb]), 64'd3);

        // Round-robin pointer now at 1: a tie goes to port 1
        gb = g_port.size(); rb1 = r_cnt[1];
        set_req(0, 1'b1, 1'b0, 32'h1100, '0);
        set_req(1, 1'b1, 1'b0, 32'h1200, '0);
        wait_grants(gb + 1, 20, "t1b_grant");
        req_valid = '0;
        wait_resps(1, rb1 + 1, 20, "t1b_resp");
        step(2);
        chk("t1b_rr_port1", 64'(g_port[gb]), 64'd1);
        chk("t1b_rdata", r_last[1], 64'h0000_1200_ffff_edff);

        // Both ports reading continuously, 2-cycle memory
        do_reset();
        resp_lat = 2; mem_ready = 1'b1;
        gb = g_port.size(); rb0 = r_cnt[0]; rb1 = r_cnt[1];
        set_req(0, 1'b1, 1'b0, 32'h2000, '0);
        set_req(1, 1'b1, 1'b0, 32'h3000, '0);
        wait_grants(gb + 8, 100, "t2_grants");
        req_valid = '0;
        wait_resps(1, rb1 + 4, 20, "t2_resp");
        step(2);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), 64'(g_port[gb + i]), 64'(i % 2));
        chk("t2_regrant_gap", 64'(g_cyc[gb + 1] - g_cyc[gb]), 64'd3);
        chk("t2_resp_p0", 64'(r_cnt[0] - rb0), 64'd4);
        chk("t2_resp_p1", 64'(r_cnt[1] - rb1), 64'd4);

        // Port 1 dumping writebacks pre-empt port 0 reads
        do_reset();
        resp_lat = 2; mem_ready = 1'b1;
        gb = g_port.size(); rb0 = r_cnt[0];
        set_req(0, 1'b1, 1'b0, 32'h4000, '0);
        set_req(1, 1'b1, 1'b1, 32'h5000, 64'hdead_beef_0000_0001);
        dumping[1] = 1'b1;
        @(negedge clk);
        chk("t3_dump_or_high", 64'(mem_dumping_cache), 64'd1);
        wait_grants(gb + 3, 20, "t3_writes");
        req_valid[1] = 1'b0;
        dumping[1]   = 1'b0;
        wait_grants(gb + 4, 20, "t3_read");
        req_valid[0] = 1'b0;
        wait_resps(0, rb0 + 1, 20, "t3_resp");
        @(negedge clk);
        chk("t3_dump_or_low", 64'(mem_dumping_cache), 64'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("t3_write%0d", i), 64'(g_port[gb + i]), 64'd1);
        chk("t3_read_after", 64'(g_port[gb + 3]), 64'd0);
        chk("t3_b2b_write", 64'(g_cyc[gb + 1] - g_cyc[gb]), 64'd1);
        chk("t3_b2b_switch", 64'(g_cyc[gb + 3] - g_cyc[gb + 2]), 64'd1);
        @(posedge clk);
        #1;

        // Grant locked in ISSUE while memory stalls and port 1 starts dumping
        do_reset();
        resp_lat = 2; mem_ready = 1'b0;
        gb = g_port.size();
        set_req(0, 1'b1, 1'b0, 32'h6000, '0);
        step(1);
        set_req(1, 1'b1, 1'b1, 32'h6800, 64'h0123_4567_89ab_cdef);
        dumping[1] = 1'b1;
        step(3);
        @(negedge clk);
        chk("t4_hold_owner", 64'(owner), 64'd0);
        chk("t4_hold_addr", 64'(mem_req_addr), 64'h6000);
        chk("t4_hold_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        rc = cyc;
        wait_grants(gb + 1, 20, "t4_grant");
        req_valid[0] = 1'b0;
        wait_grants(gb + 2, 20, "t4_second");
        req_valid[1] = 1'b0;
        dumping[1]   = 1'b0;
        step(2);
        chk("t4_first_port", 64'(g_port[gb]), 64'd0);
        chk("t4_first_cycle", 64'(g_cyc[gb] - rc), 64'd0);
        chk("t4_second_port", 64'(g_port[gb + 1]), 64'd1);

        // Spurious response while idle
        do_reset();
        rb0 = r_cnt[0]; rb1 = r_cnt[1];
        auto_en = 1'b0; man_valid = 1'b1; man_rdata = 64'h1234;
        step(1);
        man_valid = 1'b0; man_rdata = '0; auto_en = 1'b1;
        step(3);
        @(negedge clk);
        chk("t5_err_sticky", 64'(err), 64'd1);
        chk("t5_no_resp_p0", 64'(r_cnt[0] - rb0), 64'd0);
        chk("t5_no_resp_p1", 64'(r_cnt[1] - rb1), 64'd0);
        @(posedge clk);
        #1;

        // Reset while port 1 waits for its line
        do_reset();
        resp_lat = 4; mem_ready = 1'b1;
        gb = g_port.size(); rb1 = r_cnt[1];
        set_req(1, 1'b1, 1'b0, 32'h7000, '0);
        wait_grants(gb + 1, 20, "t6_grant");
        step(1);
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("t6_rst_valid", 64'(mem_req_valid), 64'd0);
        chk("t6_rst_owner", 64'(owner), 64'd0);
        chk("t6_rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(4);
        @(negedge clk);
        chk("t6_late_resp_err", 64'(err), 64'd1);
        chk("t6_no_resp_p1", 64'(r_cnt[1] - rb1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bulk_mem_arbiter.md
# bulk_mem_arbiter

Shares one line-granular backing-memory port (`bulk_read_interface`) between `N_PORTS` cache-side masters, typically the instruction and data BRAM caches. It applies round-robin arbitration to line fills and writebacks, with priority for a port that is dumping its cache. Read ownership is held until the line response returns. Responses are routed only to the owning port.

## Interface
- `N_PORTS`, 2: number of requesting caches; must be ≥2.
- `PTR_W`, `$clog2(N_PORTS)`: width of the owner and round-robin pointers.
- Line, address and strobe widths are inherited from `bulk_read_interface`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock; reset is asynchronous and active-low.
- `cache_side[N_PORTS]` `bulk_read_interface.slave`: one per cache.
  - Inputs: `req_valid/addr/write/wstrb/wdata`, `dumping_cache`.
  - Outputs: `req_ready`, `resp_valid`, `resp_rdata`.
- `mem_side` `bulk_read_interface.master`: the single downstream memory port.
- `owner` out PTR_W: index of the current or last granted port (debug).
- `err_spurious_resp` out 1: sticky; set on `mem_side.resp_valid` while no read is outstanding.

## Operation
- States:
  - `ARB`: no grant held.
  - `ISSUE`: grant locked; request presented but not yet accepted.
  - `WAIT_RESP`: read accepted; response pending.
- Winner selection in `ARB` (combinational):
  - Candidates are ports with `req_valid`.
  - If any candidate has `dumping_cache`, restrict the search to those ports.
  - Pick the first candidate at or after `rr_ptr`, wrapping modulo `N_PORTS`.
- Forwarding:
  - The winner's `req_*` fields drive `mem_side.req_*`.
  - `mem_side.req_ready` drives only the winner's `req_ready`.
  - All other ports see `req_ready=0`.
- `ARB`, winner present:
  - `owner` ← winner.
  - If `mem_side.req_ready`: a write stays in `ARB` with `rr_ptr` ← winner+1 (mod `N_PORTS`); a read goes to `WAIT_RESP`.
  - If not ready: go to `ISSUE`.
- `ISSUE`:
  - Forward `cache_side[owner]` only; no re-arbitration, even if a dumping port appears.
  - On `req_ready`: a write returns to `ARB` and advances `rr_ptr`; a read goes to `WAIT_RESP`.
  - If the owner drops `req_valid` before acceptance, return to `ARB` without advancing `rr_ptr`.
- `WAIT_RESP`:
  - All `req_ready=0`; `mem_side.req_valid=0`.
  - `cache_side[owner].resp_valid` = `mem_side.resp_valid`, and its `resp_rdata` = `mem_side.resp_rdata`.
  - Every other port sees `resp_valid=0` and `resp_rdata='0`.
  - On `resp_valid`: go to `ARB`, `rr_ptr` ← owner+1.
- `mem_side.dumping_cache` = OR of all ports' `dumping_cache` (combinational).
- `resp_valid` in `ARB` or `ISSUE` is dropped and sets `err_spurious_resp`; it is never forwarded.

## Timing
- Reset values:
  - state `ARB`, `rr_ptr=0`, `owner=0`, `err_spurious_resp=0`.
  - All `req_ready`, `resp_valid` and `mem_side.req_valid` are 0.
  - All data outputs are '0.
- Added latency: zero.
  - Request path: `ARB` → `mem_side` is combinational.
  - Response path: `mem_side` → owner is combinational.
- Back-to-back: a write accepted in cycle N lets a different port be accepted in cycle N+1.
- Response cycle:
  - A read response at cycle N lets a new grant be accepted in cycle N+1, not in cycle N.
  - In cycle N the arbiter is still in `WAIT_RESP`, so `req_ready=0`.
- Handshake: valid/ready.
  - The granted request stays stable while `ISSUE` is held.
  - A request is accepted in the cycle where both `req_valid` and `req_ready` are 1.
- Reset mid-transaction:
  - Returns to `ARB` immediately and drops any outstanding read.
  - A later response is then flagged as spurious.
- Same-cycle `resp_valid` with `rst` low: reset wins.

## Test plan
- Port0 read at 0x1000 alone; memory `req_ready=1`, response 3 cycles later with pattern A.
  - Port0 gets `resp_valid` with A exactly once.
  - Port1 never sees `resp_valid`.
  - `rr_ptr=1` afterwards.
- Both ports issue reads every cycle; memory always ready with 2-cycle response.
  - Grants alternate 0,1,0,1 over 8 transactions.
  - No port is starved.
- Port1 `dumping_cache=1` issuing writebacks, port0 reading; `rr_ptr=0`.
  - Port1 writes win until dumping drops, then port0 is granted.
  - `mem_side.dumping_cache` tracks the OR of the ports.
- `mem_side.req_ready=0` for 4 cycles while port0 waits in `ISSUE`; port1 dumping asserts meanwhile.
  - The grant stays on port0.
  - Port0 is accepted on the first ready cycle.
- `resp_valid` pulse while in `ARB` → `err_spurious_resp=1` (sticky), no port sees `resp_valid`.
- `rst` low during `WAIT_RESP` for port1.
  - State returns to `ARB`, outputs go to reset values.
  - A later response sets `err_spurious_resp`.
